tdc_hit_capture: RTL and testbench

- Single-clock time-to-digital converter channel.
- On a start pulse from core logic it runs a coarse counter. It timestamps up to 4 SPAD trigger hits, each as a coarse count plus a fine phase decoded from a 32-tap DLL thermometer bus.
- It records per-hit SPAD intensity and generates the SPAD re-arm pulse (rst_auto).
- It streams the results over a ready/valid interface and raises a frame-done interrupt.

---
 rtl/tdc_hit_capture.sv | 209 ++++++++++++++++++++
 tb/tb_tdc_hit_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_capture.sv
// Purpose : single-channel TDC; timestamps up to 4 SPAD hits per frame ({coarse, fine}),
//           records hit intensity, drives the SPAD re-arm pulse, streams hits out, flags frame done.
// Latency : hit captured on the trigger-rise edge; beats start the cycle after MEASURE exits.
// Backpressure: ready/valid out; a beat's data/intensity/last are held while TDC_Oready is low.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   DLL_Phase[31:0]     DLL tap thermometer, decoded to the 5-bit fine phase
//   TDC_start           measurement start (rising edge)
//   TDC_trigger         SPAD trigger (rising edge)
//   TDC_spaden[15:0]    SPAD fired map, popcount stored as hit intensity
//   TDC_tgate           analog time gate; stretches rst_auto while high
//   TDC_Range           timeout, compared against coarse via TDC_Range[14:5]
//   TDC_Odata/Oint/Onum/Olast/Ovalid/Oready   hit output stream
//   TDC_INT             one-cycle frame-done pulse
//   rst_auto            SPAD re-arm pulse
//
// Build option: define TDC_FINE_EN to decode the fine phase from DLL_Phase; otherwise the fine
// field reads 0 (coarse-only timestamps) and DLL_Phase is ignored.

module tdc_hit_capture #(
    parameter int RST_AUTO_CYCLES = 4,
    parameter int COARSE_W        = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           DLL_Phase,
    input  logic                  TDC_start,
    input  logic                  TDC_trigger,
    input  logic [15:0]           TDC_spaden,
    input  logic                  TDC_tgate,
    input  logic [COARSE_W+4:0]   TDC_Range,
    output logic [COARSE_W+4:0]   TDC_Odata,
    output logic [4:0]            TDC_Oint,
    output logic [1:0]            TDC_Onum,
    output logic                  TDC_Olast,
    output logic                  TDC_Ovalid,
    input  logic                  TDC_Oready,
    output logic                  TDC_INT,
    output logic                  rst_auto
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    localparam int HOLD_W = $clog2(RST_AUTO_CYCLES + 1);

    logic [1:0]          r_state;
    logic                r_start_prev;
    logic                r_trig_prev;
    logic [COARSE_W-1:0] r_coarse;
    logic [2:0]          r_count;
    logic [1:0]          r_rd_ptr;
    logic [COARSE_W+4:0] r_buf_data [4];
    logic [4:0]          r_buf_int  [4];
    logic                r_rst_auto;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_int;

    logic                w_start_rise;
    logic                w_trig_rise;
    logic [COARSE_W-1:0] w_coarse_next;
    logic                w_timeout;
    logic                w_hit;
    logic                w_last_slot;
    logic [4:0]          w_fine;
    logic [4:0]          w_popcnt;
    logic                w_unused_range;

    // Only the coarse-resolution bits of the range take part in the timeout compare.
    assign w_unused_range = ^TDC_Range[4:0];

    assign w_start_rise  = TDC_start & ~r_start_prev;
    assign w_trig_rise   = TDC_trigger & ~r_trig_prev;
    // Value the coarse counter takes on this edge; a hit on this edge is stamped with it,
    // so a trigger seen k edges after the start edge reads coarse = k.
    assign w_coarse_next = (&r_coarse) ? r_coarse : r_coarse + COARSE_W'(1);
    assign w_timeout     = r_coarse >= TDC_Range[COARSE_W+4:5];
    assign w_hit         = (r_state == S_MEASURE) && w_trig_rise && !r_rst_auto
                           && (r_count < 3'd4);
    // count == 4 wraps to 2'b00, so slot 3 is still the last one.
    assign w_last_slot   = (r_rd_ptr == (r_count[1:0] - 2'd1));

`ifdef TDC_FINE_EN
    logic [31:0] w_phase_prev;
    logic [31:0] w_phase_edge;

    // Bit i of w_phase_prev is tap (i-1) mod 32, so w_phase_edge marks 0->1 transitions
    // around the ring. All-0 / all-1 patterns have no transition and decode to 0.
    assign w_phase_prev = {DLL_Phase[30:0], DLL_Phase[31]};
    assign w_phase_edge = DLL_Phase & ~w_phase_prev;

    always_comb begin
        w_fine = '0;
        for (int i = 31; i >= 0; i--) begin
            if (w_phase_edge[i]) begin
                w_fine = 5'(i);
            end
        end
    end
`else
    logic w_unused_phase;

    assign w_unused_phase = ^DLL_Phase;
    assign w_fine         = '0;
`endif

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < 16; i++) begin
            w_popcnt = w_popcnt + {4'd0, TDC_spaden[i]};
        end
    end

    assign TDC_Ovalid = (r_state == S_OUTPUT);
    assign TDC_Odata  = TDC_Ovalid ? r_buf_data[r_rd_ptr] : '0;
    assign TDC_Oint   = TDC_Ovalid ? r_buf_int[r_rd_ptr]  : '0;
    assign TDC_Onum   = TDC_Ovalid ? (r_count[1:0] - 2'd1) : '0;
    assign TDC_Olast  = TDC_Ovalid && w_last_slot;
    assign TDC_INT    = r_int;
    assign rst_auto   = r_rst_auto;

    // Re-arm pulse: raised by a capture, held while the time gate is open, then held
    // RST_AUTO_CYCLES more cycles. Independent of the frame state so a frame exit
    // never truncates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_auto <= 1'b0;
            r_hold     <= '0;
        end else if (w_hit) begin
            r_rst_auto <= 1'b1;
            r_hold     <= HOLD_W'(RST_AUTO_CYCLES);
        end else if (r_rst_auto) begin
            if (TDC_tgate) begin
                r_hold <= HOLD_W'(RST_AUTO_CYCLES);
            end else if (r_hold <= HOLD_W'(1)) begin
                r_rst_auto <= 1'b0;
                r_hold     <= '0;
            end else begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b0;
            r_trig_prev  <= 1'b0;
            r_coarse     <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_int        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_buf_data[i] <= '0;
                r_buf_int[i]  <= '0;
            end
        end else begin
            r_start_prev <= TDC_start;
            r_trig_prev  <= TDC_trigger;
            r_int        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_coarse <= '0;
                        r_count  <= '0;
                        r_rd_ptr <= '0;
                        r_state  <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    r_coarse <= w_coarse_next;
                    if (w_hit) begin
                        r_buf_data[r_count[1:0]] <= {w_coarse_next, w_fine};
                        r_buf_int[r_count[1:0]]  <= w_popcnt;
                        r_count                  <= r_count + 3'd1;
                    end
                    // A hit landing on the timeout edge is kept before leaving.
                    if (w_timeout || (w_hit && (r_count == 3'd3))) begin
                        r_rd_ptr <= '0;
                        if (w_hit || (r_count != 3'd0)) begin
                            r_state <= S_OUTPUT;
                        end else begin
                            r_state <= S_IDLE;
                            r_int   <= 1'b1;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (TDC_Oready) begin
                        if (w_last_slot) begin
                            r_state  <= S_IDLE;
                            r_count  <= '0;
                            r_rd_ptr <= '0;
                            r_int    <= 1'b1;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_hit_capture.sv
// Purpose : self-checking bench for tdc_hit_capture.
// Latency : n/a (bench).
// Backpressure: drives TDC_Oready low for stretches to exercise beat hold.
module tb_tdc_hit_capture;

    localparam int RA = 4;
`ifdef TDC_FINE_EN
    localparam bit FINE_ON = 1'b1;
`else
    localparam bit FINE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] DLL_Phase;
    logic        TDC_start;
    logic        TDC_trigger;
    logic [15:0] TDC_spaden;
    logic        TDC_tgate;
    logic [14:0] TDC_Range;
    logic [14:0] TDC_Odata;
    logic [4:0]  TDC_Oint;
    logic [1:0]  TDC_Onum;
    logic        TDC_Olast;
    logic        TDC_Ovalid;
    logic        TDC_Oready;
    logic        TDC_INT;
    logic        rst_auto;

    always #5 clk = ~clk;

    tdc_hit_capture #(.RST_AUTO_CYCLES(RA), .COARSE_W(10)) dut (
        .clk(clk), .rst(rst), .DLL_Phase(DLL_Phase), .TDC_start(TDC_start),
        .TDC_trigger(TDC_trigger), .TDC_spaden(TDC_spaden), .TDC_tgate(TDC_tgate),
        .TDC_Range(TDC_Range), .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint),
        .TDC_Onum(TDC_Onum), .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid),
        .TDC_Oready(TDC_Oready), .TDC_INT(TDC_INT), .rst_auto(rst_auto)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired t=%0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [14:0] data; logic [4:0] oint; } beat_t;
    typedef struct packed { logic [14:0] data; logic [4:0] oint; logic last; logic [1:0] num; } got_t;

    function automatic logic [4:0] model_fine(input logic [31:0] p);
        logic [4:0] d;
        d = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (p[i] && !p[(i == 0) ? 31 : i - 1]) d = 5'(i);
        end
        return FINE_ON ? d : 5'd0;
    endfunction

    int     edge_n = 0;
    bit     m_started = 0;
    bit     m_meas = 0, m_out = 0, m_int = 0, m_ra = 0;
    bit     m_pstart = 0, m_ptrig = 0;
    int     m_t0 = 0, m_lowrun = 0, m_total = 0;
    beat_t  m_q[$];

    // Timestamps are measured from the edge where the start rise was seen.
    always @(posedge clk) begin
        bit srise, trise, cap, nint;
        int c_hit, c_reg;
        edge_n++;
        nint = 0;
        if (rst) begin
            m_started = 1; m_meas = 0; m_out = 0; m_ra = 0; m_lowrun = 0;
            m_pstart = 0; m_ptrig = 0; m_total = 0;
            m_q.delete();
        end else begin
            srise = TDC_start && !m_pstart;
            trise = TDC_trigger && !m_ptrig;
            cap   = m_meas && trise && !m_ra && (m_q.size() < 4);
            if (m_meas) begin
                c_hit = edge_n - m_t0;     if (c_hit > 1023) c_hit = 1023;
                c_reg = edge_n - 1 - m_t0; if (c_reg > 1023) c_reg = 1023;
                if (cap) m_q.push_back({10'(c_hit), model_fine(DLL_Phase), 5'($countones(TDC_spaden))});
                if (c_reg >= int'(TDC_Range[14:5]) || m_q.size() == 4) begin
                    m_meas = 0;
                    if (m_q.size() > 0) begin m_out = 1; m_total = m_q.size(); end
                    else nint = 1;
                end
            end else if (m_out) begin
                if (TDC_Oready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin m_out = 0; nint = 1; end
                end
            end else if (srise) begin
                m_meas = 1;
                m_t0   = edge_n;
            end
            if (cap) begin
                m_ra = 1; m_lowrun = 0;
            end else if (m_ra) begin
                if (TDC_tgate) m_lowrun = 0;
                else begin
                    m_lowrun++;
                    if (m_lowrun >= RA) m_ra = 0;
                end
            end
            m_pstart = TDC_start;
            m_ptrig  = TDC_trigger;
        end
        m_int = nint;
    end

    // ---------------- compare / monitor ----------------
    int   valid_seen = 0;
    int   int_seen = 0;
    got_t got[$];

    always @(negedge clk) begin
        if (m_started) begin
            chk("m_valid", {31'd0, TDC_Ovalid}, {31'd0, m_out});
            chk("m_rst_auto", {31'd0, rst_auto}, {31'd0, m_ra});
            chk("m_int", {31'd0, TDC_INT}, {31'd0, m_int});
            if (m_out && m_q.size() > 0) begin
                chk("m_odata", {17'd0, TDC_Odata}, {17'd0, m_q[0].data});
                chk("m_oint", {27'd0, TDC_Oint}, {27'd0, m_q[0].oint});
                chk("m_onum", {30'd0, TDC_Onum}, {30'd0, 2'(m_total - 1)});
                chk("m_olast", {31'd0, TDC_Olast}, {31'd0, m_q.size() == 1});
            end
        end
        if (TDC_Ovalid === 1'b1) valid_seen++;
        if (TDC_INT === 1'b1) int_seen++;
        if (TDC_Ovalid === 1'b1 && TDC_Oready === 1'b1)
            got.push_back({TDC_Odata, TDC_Oint, TDC_Olast, TDC_Onum});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        TDC_start = 1'b1;
        step(1);
        TDC_start = 1'b0;
    endtask

    task automatic wait_ra_low();
        int n = 0;
        while (rst_auto && n < 100) begin step(1); n++; end
        if (n >= 100) timeout_fail("wait_ra_low");
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!TDC_Ovalid && n < 2000) begin step(1); n++; end
        if (n >= 2000) timeout_fail(name);
    endtask

    task automatic wait_int(input string name);
        int n = 0;
        while (!TDC_INT && n < 500) begin step(1); n++; end
        if (n >= 500) timeout_fail(name);
    endtask

    // One trigger; gate = cycles tgate stays high; ra_len = rst_auto high cycles seen.
    task automatic hit(input logic [31:0] ph, input logic [15:0] sp, input int gate, output int ra_len);
        DLL_Phase   = ph;
        TDC_spaden  = sp;
        TDC_trigger = 1'b1;
        step(1);
        TDC_trigger = 1'b0;
        TDC_tgate   = (gate > 0);
        ra_len = 0;
        while (rst_auto && ra_len < 100) begin
            if (ra_len == gate) TDC_tgate = 1'b0;
            step(1);
            ra_len++;
        end
        TDC_tgate = 1'b0;
        if (ra_len >= 100) timeout_fail("hit_ra_fall");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int    n;
        logic [14:0] s_data;
        logic [4:0]  s_int;
        logic        s_last;
        int    exp_int [4];
        exp_int = '{4, 8, 12, 16};

        rst = 1'b1; TDC_start = 0; TDC_trigger = 0; TDC_tgate = 0;
        TDC_spaden = 0; DLL_Phase = 0; TDC_Range = 0; TDC_Oready = 1;

        // Reset
        step(2);
        chk("rst_valid", {31'd0, TDC_Ovalid}, 32'd0);
        chk("rst_int", {31'd0, TDC_INT}, 32'd0);
        chk("rst_ra", {31'd0, rst_auto}, 32'd0);
        chk("rst_odata", {17'd0, TDC_Odata}, 32'd0);
        chk("rst_oint", {27'd0, TDC_Oint}, 32'd0);
        chk("rst_onum", {30'd0, TDC_Onum}, 32'd0);
        chk("rst_olast", {31'd0, TDC_Olast}, 32'd0);
        rst = 1'b0;
        step(1);

        // Single hit at k=20, timeout at coarse 63
        TDC_Range = 15'h07FC; TDC_Oready = 1;
        do_start();
        step(19);
        hit(32'hFFFF0000, 16'h000F, 3, n);
        chk("single_ra_len", n, 32'd7);
        wait_valid("single_valid");
        chk("single_odata", {17'd0, TDC_Odata}, {17'd0, 10'd20, FINE_ON ? 5'd16 : 5'd0});
        chk("single_oint", {27'd0, TDC_Oint}, 32'd4);
        chk("single_onum", {30'd0, TDC_Onum}, 32'd0);
        chk("single_olast", {31'd0, TDC_Olast}, 32'd1);
        step(1);
        chk("single_int_pulse", {31'd0, TDC_INT}, 32'd1);
        chk("single_valid_drop", {31'd0, TDC_Ovalid}, 32'd0);
        step(1);
        chk("single_int_once", {31'd0, TDC_INT}, 32'd0);

        // Four hits with a blanked trigger and mid-frame backpressure
        step(2);
        TDC_Range = 15'h7FFF; TDC_Oready = 0;
        got.delete();
        do_start();
        step(9);
        DLL_Phase = 32'hFFFF0000; TDC_spaden = 16'h000F; TDC_trigger = 1;
        step(1);
        TDC_trigger = 0; TDC_tgate = 1;
        step(1);
        chk("blank_ra_high", {31'd0, rst_auto}, 32'd1);
        TDC_spaden = 16'h0001; DLL_Phase = 32'h0; TDC_trigger = 1;
        step(1);
        TDC_trigger = 0; TDC_tgate = 0;
        wait_ra_low();
        step(2);
        hit(32'h000FFFF0, 16'h00FF, 0, n);
        chk("ra_len_nogate", n, 32'd4);
        step(3);
        hit(32'h80000001, 16'h0FFF, 1, n);
        step(1);
        hit(32'hFFFFFFFF, 16'hFFFF, 2, n);
        chk("four_valid", {31'd0, TDC_Ovalid}, 32'd1);
        s_data = TDC_Odata; s_int = TDC_Oint; s_last = TDC_Olast;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp0_valid", {31'd0, TDC_Ovalid}, 32'd1);
            chk("bp0_data", {17'd0, TDC_Odata}, {17'd0, s_data});
            chk("bp0_int", {27'd0, TDC_Oint}, {27'd0, s_int});
            chk("bp0_last", {31'd0, TDC_Olast}, {31'd0, s_last});
        end
        TDC_Oready = 1;
        step(1);
        TDC_Oready = 0;
        s_data = TDC_Odata; s_int = TDC_Oint; s_last = TDC_Olast;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp1_valid", {31'd0, TDC_Ovalid}, 32'd1);
            chk("bp1_data", {17'd0, TDC_Odata}, {17'd0, s_data});
            chk("bp1_int", {27'd0, TDC_Oint}, {27'd0, s_int});
            chk("bp1_last", {31'd0, TDC_Olast}, {31'd0, s_last});
        end
        TDC_Oready = 1;
        wait_int("four_int");
        step(1);
        chk("four_nbeats", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("four_oint", {27'd0, got[i].oint}, exp_int[i]);
            chk("four_olast", {31'd0, got[i].last}, {31'd0, i == 3});
            chk("four_onum", {30'd0, got[i].num}, 32'd3);
        end
        if (got.size() == 4) begin
            chk("four_d0", {17'd0, got[0].data}, {17'd0, 10'd10, FINE_ON ? 5'd16 : 5'd0});
            chk("four_f1", {27'd0, got[1].data[4:0]}, FINE_ON ? 32'd4 : 32'd0);
            chk("four_f2", {27'd0, got[2].data[4:0]}, FINE_ON ? 32'd31 : 32'd0);
            chk("four_f3", {27'd0, got[3].data[4:0]}, 32'd0);
        end

        // Empty frame
        step(2);
        TDC_Range = 15'h0100; TDC_Oready = 1;
        int_seen = 0; valid_seen = 0;
        do_start();
        step(40);
        chk("empty_int_count", int_seen, 32'd1);
        chk("empty_valid_count", valid_seen, 32'd0);

        // Start during OUTPUT is ignored
        TDC_Oready = 0;
        do_start();
        step(2);
        hit(32'hFFFF0000, 16'h0003, 0, n);
        wait_valid("outstart_valid");
        TDC_start = 1;
        step(2);
        TDC_start = 0;
        step(2);
        TDC_Oready = 1;
        wait_int("outstart_int");
        step(1);
        int_seen = 0; valid_seen = 0;
        step(30);
        chk("outstart_no_int", int_seen, 32'd0);
        chk("outstart_no_valid", valid_seen, 32'd0);

        // Reset mid-measurement discards the captured hit
        TDC_Range = 15'h7FFF; TDC_Oready = 1;
        do_start();
        step(4);
        TDC_spaden = 16'h00FF; TDC_trigger = 1;
        step(1);
        TDC_trigger = 0; TDC_tgate = 1;
        step(1);
        chk("midrst_ra_before", {31'd0, rst_auto}, 32'd1);
        rst = 1;
        step(1);
        rst = 0; TDC_tgate = 0;
        chk("midrst_ra_after", {31'd0, rst_auto}, 32'd0);
        chk("midrst_valid", {31'd0, TDC_Ovalid}, 32'd0);
        int_seen = 0; valid_seen = 0;
        step(20);
        chk("midrst_no_valid", valid_seen, 32'd0);
        chk("midrst_no_int", int_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
